// File: rtl/forward_hazard_unit.sv
// Forwarding and load-use hazard unit sitting at the ID stage of the MIPS pipeline.
// Tracks the destination of every in-flight instruction and picks, per operand,
// the youngest stage able to supply a value, stalling ID when that producer is
// a load whose data is not yet available.
module forward_hazard_unit #(
    parameter int DEPTH            = 3,
    parameter int SEL_W            = 2,
    parameter int LOAD_READY_STAGE = 2,
    parameter int CNT_W            = 16
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [31:0]      Instruction_IN,
    input  logic             Valid_IN,
    input  logic             Flush_IN,
    output logic             Stall_OUT,
    output logic [SEL_W-1:0] ForwardA_OUT,
    output logic [SEL_W-1:0] ForwardB_OUT,
    output logic [CNT_W-1:0] StallCount_OUT
);

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [5:0] funct;
    logic       unused_shamt;

    assign opcode       = Instruction_IN[31:26];
    assign rs           = Instruction_IN[25:21];
    assign rt           = Instruction_IN[20:16];
    assign rd           = Instruction_IN[15:11];
    assign funct        = Instruction_IN[5:0];
    assign unused_shamt = ^Instruction_IN[10:6];

    logic [4:0] id_dest;
    logic       id_we;
    logic       id_load;
    logic       use_rs;
    logic       use_rt;

    // Decode destination, write-enable, load flag and operand usage of the ID instruction
    always_comb begin
        id_dest = 5'd0;
        id_we   = 1'b0;
        id_load = 1'b0;
        use_rs  = 1'b1;
        use_rt  = 1'b0;
        case (opcode) inside
            6'h00: begin
                id_dest = rd;
                id_we   = (funct != 6'h08);
                use_rt  = 1'b1;
            end
            [6'h08:6'h0F]: begin
                id_dest = rt;
                id_we   = 1'b1;
            end
            [6'h20:6'h25]: begin
                id_dest = rt;
                id_we   = 1'b1;
                id_load = 1'b1;
            end
            [6'h28:6'h2B], 6'h04, 6'h05: begin
                use_rt = 1'b1;
            end
            6'h03: begin
                id_dest = 5'd31;
                id_we   = 1'b1;
                use_rs  = 1'b0;
            end
            6'h02: begin
                use_rs = 1'b0;
            end
            default: begin
                use_rs = 1'b1;
            end
        endcase
        if (id_dest == 5'd0) begin
            id_we = 1'b0;
        end
    end

    logic [DEPTH:1] st_valid;
    logic [DEPTH:1] st_we;
    logic [DEPTH:1] st_load;
    logic [4:0]     st_dest [1:DEPTH];
    logic           enter_id;

    // A stalled or flushed instruction must not appear downstream; a bubble goes in instead
    assign enter_id = Valid_IN & ~Flush_IN & ~Stall_OUT;

    // Stage shift register: every entry advances one stage per cycle, the oldest retires
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            st_valid <= '0;
            st_we    <= '0;
            st_load  <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                st_dest[k] <= 5'd0;
            end
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                st_valid[k] <= st_valid[k-1];
                st_we[k]    <= st_we[k-1];
                st_load[k]  <= st_load[k-1];
                st_dest[k]  <= st_dest[k-1];
            end
            st_valid[1] <= enter_id;
            st_we[1]    <= enter_id & id_we;
            st_load[1]  <= enter_id & id_load;
            st_dest[1]  <= enter_id ? id_dest : 5'd0;
        end
    end

    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             early_load_a;
    logic             early_load_b;

    // Youngest-match search: scanning oldest to youngest lets the youngest overwrite
    always_comb begin
        sel_a        = '0;
        sel_b        = '0;
        early_load_a = 1'b0;
        early_load_b = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (st_valid[k] && st_we[k] && use_rs && (rs != 5'd0) && (st_dest[k] == rs)) begin
                sel_a        = SEL_W'(k);
                early_load_a = st_load[k] && (k < LOAD_READY_STAGE);
            end
            if (st_valid[k] && st_we[k] && use_rt && (rt != 5'd0) && (st_dest[k] == rt)) begin
                sel_b        = SEL_W'(k);
                early_load_b = st_load[k] && (k < LOAD_READY_STAGE);
            end
        end
    end

    assign ForwardA_OUT = Valid_IN ? sel_a : '0;
    assign ForwardB_OUT = Valid_IN ? sel_b : '0;
    assign Stall_OUT    = Valid_IN & ~Flush_IN & (early_load_a | early_load_b);

    // Saturating count of cycles spent stalled
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            StallCount_OUT <= '0;
        end else if (Stall_OUT && (StallCount_OUT != {CNT_W{1'b1}})) begin
            StallCount_OUT <= StallCount_OUT + 1'b1;
        end
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Scoreboard bench for forward_hazard_unit: a default instance plus a
// DEPTH=5 / LOAD_READY_STAGE=4 instance with a 2-bit counter to show saturation.
module tb_forward_hazard_unit;

    logic        clock;
    logic        reset;
    logic [31:0] instr0, instr1;
    logic        valid0, valid1;
    logic        flush0, flush1;
    logic        stall0, stall1;
    logic [1:0]  fa0, fb0;
    logic [2:0]  fa1, fb1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    typedef struct {
        bit         which;
        logic [2:0] fa;
        logic [2:0] fb;
        logic       st;
        logic [15:0] cnt;
        string      name;
    } expect_t;

    expect_t scoreboard[$];
    int      checks   = 0;
    int      failures = 0;
    bit      done     = 0;

    forward_hazard_unit dut (
        .CLOCK(clock), .RESET(reset), .Instruction_IN(instr0), .Valid_IN(valid0),
        .Flush_IN(flush0), .Stall_OUT(stall0), .ForwardA_OUT(fa0), .ForwardB_OUT(fb0),
        .StallCount_OUT(cnt0)
    );

    forward_hazard_unit #(.DEPTH(5), .SEL_W(3), .LOAD_READY_STAGE(4), .CNT_W(2)) dut5 (
        .CLOCK(clock), .RESET(reset), .Instruction_IN(instr1), .Valid_IN(valid1),
        .Flush_IN(flush1), .Stall_OUT(stall1), .ForwardA_OUT(fa1), .ForwardB_OUT(fb1),
        .StallCount_OUT(cnt1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] rtype(int rs, int rt, int rd, int funct);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
    endfunction

    function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // Drive one ID cycle on the chosen instance and queue its expected response
    task automatic applyStimulus(input bit which, input logic [31:0] ins, input logic v,
                                 input logic f, input logic r, input string name,
                                 input int efa, input int efb, input int est, input int ecnt);
        expect_t e;
        @(posedge clock);
        #1;
        reset = r;
        if (which == 1'b0) begin
            instr0 = ins; valid0 = v; flush0 = f;
            valid1 = 1'b0; flush1 = 1'b0;
        end else begin
            instr1 = ins; valid1 = v; flush1 = f;
            valid0 = 1'b0; flush0 = 1'b0;
        end
        e.which = which;
        e.fa    = 3'(efa);
        e.fb    = 3'(efb);
        e.st    = 1'(est);
        e.cnt   = 16'(ecnt);
        e.name  = name;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    // Monitor: whenever a response is pending, compare the DUT mid-cycle
    always @(negedge clock) begin
        expect_t e;
        if (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            if (e.which == 1'b0) begin
                checkOutput({e.name, " fwdA"},  int'(fa0),    int'(e.fa));
                checkOutput({e.name, " fwdB"},  int'(fb0),    int'(e.fb));
                checkOutput({e.name, " stall"}, int'(stall0), int'(e.st));
                checkOutput({e.name, " count"}, int'(cnt0),   int'(e.cnt));
            end else begin
                checkOutput({e.name, " fwdA"},  int'(fa1),    int'(e.fa));
                checkOutput({e.name, " fwdB"},  int'(fb1),    int'(e.fb));
                checkOutput({e.name, " stall"}, int'(stall1), int'(e.st));
                checkOutput({e.name, " count"}, int'(cnt1),   int'(e.cnt));
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        if (!done) begin
            $display("[TB] FAIL watchdog: got timeout, expected completion");
            $fatal(1, "[TB] watchdog expired");
        end
    end

    // Directed sequence with hand-computed expectations
    initial begin
        reset = 1'b1;
        instr0 = '0; valid0 = 1'b0; flush0 = 1'b0;
        instr1 = '0; valid1 = 1'b0; flush1 = 1'b0;
        repeat (3) @(posedge clock);

        applyStimulus(0, rtype(1, 2, 3, 'h20),   1, 0, 0, "reset_add",  0, 0, 0, 0);
        applyStimulus(0, rtype(3, 4, 5, 'h22),   1, 0, 0, "sub_fwd",    1, 0, 0, 0);
        applyStimulus(0, itype('h23, 9, 8, 0),   1, 0, 0, "lw8",        0, 0, 0, 0);
        applyStimulus(0, rtype(8, 8, 10, 'h20),  1, 0, 0, "loaduse",    1, 1, 1, 0);
        applyStimulus(0, rtype(8, 8, 10, 'h20),  1, 0, 0, "loaduse_go", 2, 2, 0, 1);
        applyStimulus(0, itype('h08, 4, 4, 1),   1, 0, 0, "addi1",      0, 0, 0, 1);
        applyStimulus(0, itype('h08, 4, 4, 2),   1, 0, 0, "addi2",      1, 0, 0, 1);
        applyStimulus(0, itype('h2B, 4, 4, 0),   1, 0, 0, "sw_young",   1, 1, 0, 1);
        applyStimulus(0, itype('h0D, 1, 0, 5),   1, 0, 0, "ori0",       0, 0, 0, 1);
        applyStimulus(0, rtype(0, 0, 2, 'h20),   1, 0, 0, "add_r0",     0, 0, 0, 1);
        applyStimulus(0, itype('h23, 0, 7, 0),   1, 0, 0, "lw7",        0, 0, 0, 1);
        applyStimulus(0, itype('h04, 7, 7, 0),   1, 1, 0, "beq_flush",  1, 1, 0, 1);
        applyStimulus(0, itype('h08, 0, 14, 1),  1, 1, 0, "addi_flush", 0, 0, 0, 1);
        applyStimulus(0, rtype(14, 14, 15, 'h22),1, 0, 0, "bubble",     0, 0, 0, 1);
        applyStimulus(0, itype('h23, 0, 20, 0),  1, 0, 0, "lw20",       0, 0, 0, 1);
        applyStimulus(0, itype('h08, 0, 20, 3),  1, 0, 0, "addi20",     0, 0, 0, 1);
        applyStimulus(0, rtype(20, 20, 21, 'h20),1, 0, 0, "hidden_ld",  1, 1, 0, 1);
        applyStimulus(0, rtype(20, 20, 22, 'h20),0, 0, 0, "invalid",    0, 0, 0, 1);
        applyStimulus(0, itype('h23, 0, 9, 0),   1, 0, 0, "lw9",        0, 0, 0, 1);
        applyStimulus(0, rtype(9, 0, 1, 'h20),   1, 0, 1, "stall_rst",  1, 0, 1, 1);
        applyStimulus(0, rtype(9, 0, 1, 'h20),   1, 0, 0, "after_rst",  0, 0, 0, 0);

        applyStimulus(1, itype('h23, 9, 8, 0),   1, 0, 0, "d5_lw",      0, 0, 0, 0);
        applyStimulus(1, rtype(8, 8, 10, 'h20),  1, 0, 0, "d5_stall1",  1, 1, 1, 0);
        applyStimulus(1, rtype(8, 8, 10, 'h20),  1, 0, 0, "d5_stall2",  2, 2, 1, 1);
        applyStimulus(1, rtype(8, 8, 10, 'h20),  1, 0, 0, "d5_stall3",  3, 3, 1, 2);
        applyStimulus(1, rtype(8, 8, 10, 'h20),  1, 0, 0, "d5_go",      4, 4, 0, 3);
        applyStimulus(1, itype('h23, 0, 11, 0),  1, 0, 0, "d5_lw11",    0, 0, 0, 3);
        applyStimulus(1, rtype(11, 0, 12, 'h20), 1, 0, 0, "d5_sat1",    1, 0, 1, 3);
        applyStimulus(1, rtype(11, 0, 12, 'h20), 1, 0, 0, "d5_sat2",    2, 0, 1, 3);
        applyStimulus(1, rtype(11, 0, 12, 'h20), 1, 0, 0, "d5_sat3",    3, 0, 1, 3);
        applyStimulus(1, rtype(11, 0, 12, 'h20), 1, 0, 0, "d5_sat_go",  4, 0, 0, 3);

        repeat (3) @(posedge clock);
        checkOutput("scoreboard_drained", scoreboard.size(), 0);
        done = 1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
